// File: rtl/fir_mac_sched.sv
// fir_mac_sched
// Two-channel (IR / RED) 22-tap symmetric FIR filter sharing a single
// serial multiply-accumulate unit. Each accepted sample shifts the granted
// channel's history, then 11 MAC cycles fold the symmetric tap pairs
// (h[i] + h[21-i]) and a one-cycle DONE state publishes the result.
//
// Handshake: a sample transfers on a rising edge where valid && ready.
// ready is combinational, high only in IDLE and only for the channel the
// arbiter grants this cycle. Requesters must hold valid until ready.
//
// Ports
//   CLK_Filter     in   filter clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   ir_valid       in   IR sample request
//   ir_sample[7:0] in   IR ADC value (unsigned)
//   red_valid      in   RED sample request
//   red_sample[7:0] in  RED ADC value (unsigned)
//   ir_ready       out  IR sample accepted this cycle when ir_valid=1
//   red_ready      out  RED sample accepted this cycle when red_valid=1
//   ir_out[19:0]   out  last IR filtered result
//   ir_out_valid   out  one-cycle pulse when ir_out updates
//   red_out[19:0]  out  last RED filtered result
//   red_out_valid  out  one-cycle pulse when red_out updates
//   busy           out  high whenever the FSM is not in IDLE
//
// Configuration
//   FIR_SCHED_RR_EN  defined: round-robin arbitration between channels.
//                    undefined (default): fixed priority, IR wins.

module fir_mac_sched (
  input  logic        CLK_Filter,
  input  logic        rst_n,
  input  logic        ir_valid,
  input  logic [7:0]  ir_sample,
  input  logic        red_valid,
  input  logic [7:0]  red_sample,
  output logic        ir_ready,
  output logic        red_ready,
  output logic [19:0] ir_out,
  output logic        ir_out_valid,
  output logic [19:0] red_out,
  output logic        red_out_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  tap;
  logic [19:0] acc;
  logic        sel_red;     // channel being computed: 0 = IR, 1 = RED
  logic [7:0]  ir_h  [22];
  logic [7:0]  red_h [22];

`ifdef FIR_SCHED_RR_EN
  logic        rr_ir_prio;  // 1: IR wins the next contested grant
`endif

  logic        grant_ir;
  logic        grant_red;
  logic [4:0]  idx_new;
  logic [4:0]  idx_old;
  logic [7:0]  h_new;
  logic [7:0]  h_old;
  logic [8:0]  pair_sum;
  logic [7:0]  coef;
  logic [16:0] prod;
  logic [19:0] acc_next;

  function automatic logic [7:0] coef_lut(input logic [3:0] i);
    case (i)
      4'd0:    coef_lut = 8'd2;
      4'd1:    coef_lut = 8'd10;
      4'd2:    coef_lut = 8'd16;
      4'd3:    coef_lut = 8'd28;
      4'd4:    coef_lut = 8'd43;
      4'd5:    coef_lut = 8'd60;
      4'd6:    coef_lut = 8'd78;
      4'd7:    coef_lut = 8'd95;
      4'd8:    coef_lut = 8'd111;
      4'd9:    coef_lut = 8'd122;
      4'd10:   coef_lut = 8'd128;
      default: coef_lut = 8'd0;
    endcase
  endfunction

  // Arbitration: only meaningful in IDLE; at most one grant is ever high.
  always_comb begin
    grant_ir  = 1'b0;
    grant_red = 1'b0;
    if (state == S_IDLE) begin
`ifdef FIR_SCHED_RR_EN
      if (ir_valid && red_valid) begin
        grant_ir  = rr_ir_prio;
        grant_red = !rr_ir_prio;
      end else begin
        grant_ir  = ir_valid;
        grant_red = red_valid;
      end
`else
      grant_ir  = ir_valid;
      grant_red = red_valid && !ir_valid;
`endif
    end
  end

  assign ir_ready  = grant_ir;
  assign red_ready = grant_red;
  assign busy      = (state != S_IDLE);

  // Folded symmetric tap: coefficient i multiplies h[i] + h[21-i].
  always_comb begin
    idx_new  = {1'b0, tap};
    idx_old  = 5'd21 - {1'b0, tap};
    h_new    = sel_red ? red_h[idx_new] : ir_h[idx_new];
    h_old    = sel_red ? red_h[idx_old] : ir_h[idx_old];
    pair_sum = {1'b0, h_new} + {1'b0, h_old};
    coef     = coef_lut(tap);
    prod     = {9'd0, coef} * {8'd0, pair_sum};
    acc_next = acc + {3'd0, prod};
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tap           <= 4'd0;
      acc           <= 20'd0;
      sel_red       <= 1'b0;
      ir_out        <= 20'd0;
      red_out       <= 20'd0;
      ir_out_valid  <= 1'b0;
      red_out_valid <= 1'b0;
`ifdef FIR_SCHED_RR_EN
      rr_ir_prio    <= 1'b1;
`endif
      for (int k = 0; k < 22; k++) begin
        ir_h[k]  <= 8'd0;
        red_h[k] <= 8'd0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ir || grant_red) begin
            sel_red <= grant_red;
            acc     <= 20'd0;
            tap     <= 4'd0;
            state   <= S_MAC;
            if (grant_red) begin
              for (int k = 21; k > 0; k--) red_h[k] <= red_h[k-1];
              red_h[0] <= red_sample;
            end else begin
              for (int k = 21; k > 0; k--) ir_h[k] <= ir_h[k-1];
              ir_h[0] <= ir_sample;
            end
`ifdef FIR_SCHED_RR_EN
            // The channel just served loses priority for the next contest.
            rr_ir_prio <= grant_red;
`endif
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (tap == 4'd10) begin
            // Result registers update on entry to DONE so the pulse and the
            // new value are both visible during the DONE cycle.
            state <= S_DONE;
            if (sel_red) begin
              red_out       <= acc_next;
              red_out_valid <= 1'b1;
            end else begin
              ir_out        <= acc_next;
              ir_out_valid  <= 1'b1;
            end
          end else begin
            tap <= tap + 4'd1;
          end
        end
        S_DONE: begin
          ir_out_valid  <= 1'b0;
          red_out_valid <= 1'b0;
          tap           <= 4'd0;
          state         <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Directed bench for fir_mac_sched: reset values, impulse response, DC
// settling, handshake timing, arbitration, reset abort and interleaved
// channel streams checked against an independent 22-tap reference sum.
module tb_fir_mac_sched;

  logic        CLK_Filter = 1'b0;
  logic        rst_n      = 1'b0;
  logic        ir_valid   = 1'b0;
  logic [7:0]  ir_sample  = 8'd0;
  logic        red_valid  = 1'b0;
  logic [7:0]  red_sample = 8'd0;
  logic        ir_ready;
  logic        red_ready;
  logic [19:0] ir_out;
  logic        ir_out_valid;
  logic [19:0] red_out;
  logic        red_out_valid;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [19:0] exp_ir_out  = 20'd0;
  logic [19:0] exp_red_out = 20'd0;
  logic [7:0]  m_ir  [22];
  logic [7:0]  m_red [22];

  // Hand-computed impulse response: coefficient of the tap the 1 sits in.
  int imp_resp [22] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128,
                        128, 122, 111, 95, 78, 60, 43, 28, 16, 10, 2};

  fir_mac_sched dut (
    .CLK_Filter    (CLK_Filter),
    .rst_n         (rst_n),
    .ir_valid      (ir_valid),
    .ir_sample     (ir_sample),
    .red_valid     (red_valid),
    .red_sample    (red_sample),
    .ir_ready      (ir_ready),
    .red_ready     (red_ready),
    .ir_out        (ir_out),
    .ir_out_valid  (ir_out_valid),
    .red_out       (red_out),
    .red_out_valid (red_out_valid),
    .busy          (busy)
  );

  always #5 CLK_Filter = ~CLK_Filter;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic apply_reset();
    @(negedge CLK_Filter);
    rst_n     = 1'b0;
    ir_valid  = 1'b0;
    red_valid = 1'b0;
    for (int k = 0; k < 22; k++) begin
      m_ir[k]  = 8'd0;
      m_red[k] = 8'd0;
    end
    exp_ir_out  = 20'd0;
    exp_red_out = 20'd0;
    repeat (2) @(negedge CLK_Filter);
    rst_n = 1'b1;
  endtask

  // Reference: plain 22-tap direct form with coefficients mirrored by index.
  task automatic model_push(input bit ch, input logic [7:0] s, output logic [19:0] exp);
    int cf [11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
    int sum;
    sum = 0;
    if (ch) begin
      for (int k = 21; k > 0; k--) m_red[k] = m_red[k-1];
      m_red[0] = s;
      for (int j = 0; j < 22; j++) sum += cf[(j < 11) ? j : 21 - j] * int'(m_red[j]);
    end else begin
      for (int k = 21; k > 0; k--) m_ir[k] = m_ir[k-1];
      m_ir[0] = s;
      for (int j = 0; j < 22; j++) sum += cf[(j < 11) ? j : 21 - j] * int'(m_ir[j]);
    end
    exp = sum[19:0];
  endtask

  // Offer one sample on channel ch (0 = IR, 1 = RED), then check the full
  // 13-cycle transaction timing and the published result.
  task automatic do_sample(input bit ch, input logic [7:0] s, input logic [19:0] exp);
    int wait_cnt;
    @(negedge CLK_Filter);
    if (ch) begin red_valid = 1'b1; red_sample = s; end
    else    begin ir_valid  = 1'b1; ir_sample  = s; end
    #1;
    wait_cnt = 0;
    while (!(ch ? red_ready : ir_ready) && wait_cnt < 40) begin
      @(negedge CLK_Filter);
      #1;
      wait_cnt++;
    end
    chk("ready_timeout", {31'd0, wait_cnt < 40}, 32'd1);
    if (wait_cnt >= 40) begin
      ir_valid  = 1'b0;
      red_valid = 1'b0;
      return;
    end
    @(posedge CLK_Filter);
    #1;
    ir_valid  = 1'b0;
    red_valid = 1'b0;
    if (ch) exp_red_out = exp;
    else    exp_ir_out  = exp;
    for (int k = 1; k <= 13; k++) begin
      @(negedge CLK_Filter);
      chk("busy", {31'd0, busy}, {31'd0, k <= 12});
      chk("out_valid", {31'd0, ch ? red_out_valid : ir_out_valid}, {31'd0, k == 12});
      chk("other_valid", {31'd0, ch ? ir_out_valid : red_out_valid}, 32'd0);
      if (k == 12) begin
        chk(ch ? "red_out" : "ir_out", {12'd0, ch ? red_out : ir_out}, {12'd0, exp});
        chk(ch ? "ir_out_hold" : "red_out_hold", {12'd0, ch ? ir_out : red_out},
            {12'd0, ch ? exp_ir_out : exp_red_out});
      end
    end
  endtask

  task automatic impulse_run();
    for (int k = 0; k < 23; k++)
      do_sample(1'b0, (k == 0) ? 8'd1 : 8'd0, (k < 22) ? imp_resp[k][19:0] : 20'd0);
  endtask

  initial begin
    logic [19:0] e;
    int grant_cnt;
    int last_grant;
    bit expect_red;

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ir_out", {12'd0, ir_out}, 32'd0);
    chk("rst_red_out", {12'd0, red_out}, 32'd0);
    chk("rst_ir_ov", {31'd0, ir_out_valid}, 32'd0);
    chk("rst_red_ov", {31'd0, red_out_valid}, 32'd0);
    apply_reset();
    #1;
    chk("idle_no_ready", {30'd0, ir_ready, red_ready}, 32'd0);
    repeat (3) @(negedge CLK_Filter);
    chk("idle_stays", {31'd0, busy}, 32'd0);

    // IR impulse response
    impulse_run();

    // DC settling at 100 and at full scale
    apply_reset();
    for (int k = 0; k < 22; k++) begin
      model_push(1'b0, 8'd100, e);
      do_sample(1'b0, 8'd100, e);
    end
    chk("settle_100", {12'd0, ir_out}, 32'd138600);
    for (int k = 0; k < 22; k++) begin
      model_push(1'b0, 8'd255, e);
      do_sample(1'b0, 8'd255, e);
    end
    chk("settle_255", {12'd0, ir_out}, 32'd353430);

    // Both channels requesting continuously
    apply_reset();
    @(negedge CLK_Filter);
    ir_valid   = 1'b1;
    red_valid  = 1'b1;
    ir_sample  = 8'd0;
    red_sample = 8'd0;
    grant_cnt  = 0;
    last_grant = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      chk("ready_exclusive", {31'd0, ir_ready && red_ready}, 32'd0);
      if (busy) chk("ready_low_busy", {30'd0, ir_ready, red_ready}, 32'd0);
      else      chk("ready_in_idle", {31'd0, ir_ready || red_ready}, 32'd1);
      if (ir_ready || red_ready) begin
`ifdef FIR_SCHED_RR_EN
        expect_red = grant_cnt[0];
`else
        expect_red = 1'b0;
`endif
        chk("grant_channel", {31'd0, red_ready}, {31'd0, expect_red});
        if (grant_cnt > 0) chk("grant_period", c - last_grant, 32'd13);
        last_grant = c;
        grant_cnt++;
      end
      @(negedge CLK_Filter);
    end
    chk("grant_count", grant_cnt, 32'd5);
    ir_valid  = 1'b0;
    red_valid = 1'b0;

    // Reset in the middle of MAC aborts the computation
    apply_reset();
    do_sample(1'b0, 8'd1, 20'd2);
    do_sample(1'b0, 8'd0, 20'd10);
    @(negedge CLK_Filter);
    ir_valid  = 1'b1;
    ir_sample = 8'd0;
    #1;
    chk("abort_ready", {31'd0, ir_ready}, 32'd1);
    @(posedge CLK_Filter);
    #1;
    ir_valid = 1'b0;
    repeat (6) @(negedge CLK_Filter);   // cycle T+6: tap index 5
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ir_out", {12'd0, ir_out}, 32'd0);
    chk("abort_red_out", {12'd0, red_out}, 32'd0);
    @(negedge CLK_Filter);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK_Filter);
      chk("abort_no_pulse", {30'd0, ir_out_valid, red_out_valid}, 32'd0);
    end
    exp_ir_out  = 20'd0;
    exp_red_out = 20'd0;
    impulse_run();

    // Interleaved IR / RED streams
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      bit ch;
      logic [7:0] s;
      ch = (i % 3 == 1) || (i % 5 == 0);
      s  = 8'($urandom_range(0, 255));
      model_push(ch, s, e);
      do_sample(ch, s, e);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
